fifo_burst_drain: RTL



---
 rtl/fifo_burst_drain.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/fifo_burst_drain.sv
// fifo_burst_drain: pulls fixed-length bursts out of a registered-read
// synchronous FIFO and streams them on a valid/ready port with m_last.
// A 2-entry skid buffer absorbs the FIFO's one-cycle read latency.
// Optional build macro FIFO_BURST_TIMEOUT_EN: forces a partial burst after
// TIMEOUT idle cycles in ACCUM; without it partial data waits indefinitely.
module fifo_burst_drain #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   fifo_data,
  input  logic [$clog2(DEPTH):0]  fifo_level,
  input  logic                    fifo_empty,
  output logic                    fifo_rd_en,
  output logic [DATA_WIDTH-1:0]   m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_last,
  output logic                    busy
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;
  localparam int unsigned CW = $clog2(BURST_LEN) + 1;

  // Elaboration-time parameter sanity
  if (BURST_LEN < 1 || BURST_LEN > DEPTH) begin : g_bad_burst_len
    $error("fifo_burst_drain: BURST_LEN must be within 1..DEPTH");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("fifo_burst_drain: TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t                  state;
  logic [CW-1:0]           burst_len_q;
  logic [CW-1:0]           pops_issued;
  logic [CW-1:0]           words_sent;
  logic                    inflight;
  logic                    inflight_last;
  logic [1:0]              buf_count;
  logic [DATA_WIDTH-1:0]   head_data;
  logic                    head_last;
  logic [DATA_WIDTH-1:0]   tail_data;
  logic                    tail_last;

  logic                    hs;
  logic                    last_pop;
  logic                    level_met;
  logic [2:0]              occ_next;

  // Stream side is driven straight from the buffer head
  assign m_valid = (buf_count != 2'd0);
  assign m_data  = head_data;
  assign m_last  = head_last & m_valid;
  assign busy    = (state != IDLE);

  assign hs        = m_valid & m_ready;
  assign last_pop  = (pops_issued == burst_len_q - CW'(1));
  assign level_met = (fifo_level >= LW'(BURST_LEN));

  // Buffer slots committed after this edge; a slot emptied by this cycle's
  // handshake counts as free so a steady stream pops every cycle.
  assign occ_next = 3'(buf_count) - 3'(hs) + 3'(inflight);

  // Pop request: only in READ, while the burst is short and a slot is free
  assign fifo_rd_en = (state == READ) & ~fifo_empty &
                      (pops_issued < burst_len_q) & (occ_next < 3'd2);

`ifdef FIFO_BURST_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT) + 1;
  logic [TW-1:0] timer;
  logic          timeout_hit;

  assign timeout_hit = (timer == TW'(TIMEOUT - 1));

  // Idle timer: counts cycles spent in ACCUM, cleared everywhere else
  always_ff @(posedge clk) begin
    if (rst || state != ACCUM) begin
      timer <= '0;
    end else begin
      timer <= timer + TW'(1);
    end
  end
`endif

  // Burst control FSM with burst length latch and pop/delivery counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      burst_len_q <= '0;
      pops_issued <= '0;
      words_sent  <= '0;
    end else begin
      if (fifo_rd_en) pops_issued <= pops_issued + CW'(1);
      if (hs)         words_sent  <= words_sent + CW'(1);
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            if (level_met) begin
              state       <= READ;
              burst_len_q <= CW'(BURST_LEN);
              pops_issued <= '0;
              words_sent  <= '0;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (fifo_empty) begin
            state <= IDLE;
          end else if (level_met) begin
            state       <= READ;
            burst_len_q <= CW'(BURST_LEN);
            pops_issued <= '0;
            words_sent  <= '0;
          end
`ifdef FIFO_BURST_TIMEOUT_EN
          else if (timeout_hit) begin
            state       <= READ;
            burst_len_q <= CW'(fifo_level);
            pops_issued <= '0;
            words_sent  <= '0;
          end
`endif
        end
        READ: begin
          if (fifo_rd_en && last_pop) state <= DRAIN;
        end
        DRAIN: begin
          if (hs && words_sent == burst_len_q - CW'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read-latency tracker: marks the word arriving on fifo_data this cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= fifo_rd_en;
      inflight_last <= fifo_rd_en & last_pop;
    end
  end

  // Two-entry output buffer; head feeds the stream, tail catches overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_count <= 2'd0;
      head_data <= '0;
      head_last <= 1'b0;
      tail_data <= '0;
      tail_last <= 1'b0;
    end else if (inflight && !hs) begin
      if (buf_count == 2'd0) begin
        head_data <= fifo_data;
        head_last <= inflight_last;
      end else begin
        tail_data <= fifo_data;
        tail_last <= inflight_last;
      end
      buf_count <= buf_count + 2'd1;
    end else if (!inflight && hs) begin
      head_data <= tail_data;
      head_last <= tail_last;
      buf_count <= buf_count - 2'd1;
    end else if (inflight && hs) begin
      if (buf_count == 2'd1) begin
        head_data <= fifo_data;
        head_last <= inflight_last;
      end else begin
        head_data <= tail_data;
        head_last <= tail_last;
        tail_data <= fifo_data;
        tail_last <= inflight_last;
      end
    end
  end

endmodule
